// File: rtl/sram_bank_pwr_ctrl_if.sv
// OBI requester-side bundle between the bus/crossbar and one bank power controller.
interface sram_bank_pwr_ctrl_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sram_bank_pwr_ctrl.sv
// Per-bank SRAM power sequencer: forwards OBI traffic, auto-gates after idle, wakes on demand.
// Define SRAM_PWR_RETENTION_EN to sleep in retention instead of power-off.
//
// state       | meaning
// ACTIVE      | bank on, requests forwarded and granted combinationally
// GATE_REQ    | low-power entry requested, waiting for the bank to confirm
// OFF         | bank gated (or retained), waiting for a request or pg_en_i low
// WAKE_REQ    | power restored, waiting for the bank ack
// WAKE_SETTLE | bank powered, counting settle cycles before the first grant
module sram_bank_pwr_ctrl #(
    parameter int unsigned IDLE_CYCLES = 64,
    parameter int unsigned WAKE_CYCLES = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    sram_bank_pwr_ctrl_if.slave  bus,
    output logic                 ram_req_o,
    output logic                 ram_we_o,
    output logic [3:0]           ram_be_o,
    output logic [31:0]          ram_addr_o,
    output logic [31:0]          ram_wdata_o,
    input  logic [31:0]          ram_rdata_i,
    input  logic                 pg_en_i,
    output logic                 pwrgate_no,
    input  logic                 pwrgate_ack_ni,
    output logic                 set_retentive_no,
    output logic                 gated_o,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        ACTIVE      = 3'd0,
        GATE_REQ    = 3'd1,
        OFF         = 3'd2,
        WAKE_REQ    = 3'd3,
        WAKE_SETTLE = 3'd4
    } state_t;

    localparam bit             GATE_EN   = (IDLE_CYCLES != 0);
    localparam bit             SETTLE_EN = (WAKE_CYCLES != 0);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(GATE_EN ? IDLE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(SETTLE_EN ? WAKE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic             rvalid_q;
    logic             gnt;
    logic             idle_cyc;
    logic             wake_done;

`ifdef SRAM_PWR_RETENTION_EN
    logic unused_ack;
    assign unused_ack = pwrgate_ack_ni;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ACTIVE;
            idle_q   <= '0;
            settle_q <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            settle_q <= settle_d;
            rvalid_q <= gnt;
        end
    end

    always_comb begin
        state_d          = state_q;
        idle_d           = idle_q;
        settle_d         = settle_q;
        gnt              = 1'b0;
        pwrgate_no       = 1'b1;
        set_retentive_no = 1'b1;
        gated_o          = 1'b0;
        wake_done        = 1'b0;
        idle_cyc         = !bus.req && !rvalid_q;

        case (state_q)
            ACTIVE: begin
                gnt = bus.req;
                if (!idle_cyc) begin
                    idle_d = '0;
                end else if (GATE_EN && pg_en_i && idle_q >= IDLE_LAST) begin
                    state_d = GATE_REQ;
                    idle_d  = '0;
                end else if (idle_q != CNT_MAX) begin
                    idle_d = idle_q + 1'b1;
                end
            end
            GATE_REQ: begin
`ifdef SRAM_PWR_RETENTION_EN
                set_retentive_no = 1'b0;
                state_d          = OFF;
`else
                pwrgate_no = 1'b0;
                if (!pwrgate_ack_ni) state_d = OFF;
`endif
            end
            OFF: begin
                gated_o = 1'b1;
`ifdef SRAM_PWR_RETENTION_EN
                set_retentive_no = 1'b0;
`else
                pwrgate_no = 1'b0;
`endif
                if (bus.req || !pg_en_i) state_d = WAKE_REQ;
            end
            WAKE_REQ: begin
                settle_d = '0;
`ifdef SRAM_PWR_RETENTION_EN
                set_retentive_no = 1'b0;
                wake_done        = 1'b1;
`else
                wake_done = !pwrgate_ack_ni ? 1'b0 : 1'b1;
`endif
                if (wake_done) begin
                    state_d = SETTLE_EN ? WAKE_SETTLE : ACTIVE;
                    idle_d  = '0;
                end
            end
            WAKE_SETTLE: begin
                if (settle_q >= WAKE_LAST) begin
                    state_d  = ACTIVE;
                    idle_d   = '0;
                    settle_d = '0;
                end else if (settle_q != CNT_MAX) begin
                    settle_d = settle_q + 1'b1;
                end
            end
            default: state_d = ACTIVE;
        endcase
    end

    // Request fields pass straight through; only the strobe is gated by state.
    assign ram_req_o   = gnt;
    assign ram_we_o    = bus.we;
    assign ram_be_o    = bus.be;
    assign ram_addr_o  = bus.addr;
    assign ram_wdata_o = bus.wdata;

    assign bus.gnt    = gnt;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = ram_rdata_i;
    assign state_o    = state_q;

endmodule
